// File: rtl/beam_combiner.sv
// Burst-atomic 3:1 AXI-Stream combiner with source tagging and a sticky burst-length check.
// Two cycles from first input valid to first sink beat; the granted tready is low while the output register is full and the sink stalls.
module beam_combiner #(
    parameter int DATA_W    = 32,
    parameter int MIN_BURST = 1024,
    parameter int MAX_BURST = 65536
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] axis_adc0_tdata,
    input  logic              axis_adc0_tvalid,
    input  logic              axis_adc0_tlast,
    output logic              axis_adc0_tready,
    input  logic [DATA_W-1:0] axis_adc1_tdata,
    input  logic              axis_adc1_tvalid,
    input  logic              axis_adc1_tlast,
    output logic              axis_adc1_tready,
    input  logic [DATA_W-1:0] axis_adc2_tdata,
    input  logic              axis_adc2_tvalid,
    input  logic              axis_adc2_tlast,
    output logic              axis_adc2_tready,
    input  logic [1:0]        i_src_sel,
    output logic [DATA_W-1:0] axis_sink_tdata,
    output logic              axis_sink_tvalid,
    output logic              axis_sink_tlast,
    output logic [1:0]        axis_sink_tid,
    input  logic              axis_sink_tready,
    output logic              burst_size_error
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [17:0] MIN_LEN = 18'(MIN_BURST);
    localparam logic [17:0] MAX_LEN = 18'(MAX_BURST);

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [16:0]       len_q, len_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;
    logic [1:0]        tid_q, tid_d;
    logic              err_q, err_d;

    logic [2:0]        in_vld;
    logic              out_free;
    logic              sel_vld, sel_last, accept;
    logic [DATA_W-1:0] sel_dat;
    logic              pick_vld;
    logic [1:0]        pick, rr1, rr2, rr3, force_idx;
    logic [17:0]       burst_len;

    function automatic logic [1:0] next_src(input logic [1:0] g);
        return (g == 2'd2) ? 2'd0 : g + 2'd1;
    endfunction

    assign in_vld   = {axis_adc2_tvalid, axis_adc1_tvalid, axis_adc0_tvalid};
    assign out_free = !vld_q || axis_sink_tready;

    assign axis_adc0_tready = (state_q == GRANT) && (grant_q == 2'd0) && out_free;
    assign axis_adc1_tready = (state_q == GRANT) && (grant_q == 2'd1) && out_free;
    assign axis_adc2_tready = (state_q == GRANT) && (grant_q == 2'd2) && out_free;

    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = '0;
        case (grant_q)
            2'd0:    begin sel_vld = axis_adc0_tvalid; sel_last = axis_adc0_tlast; sel_dat = axis_adc0_tdata; end
            2'd1:    begin sel_vld = axis_adc1_tvalid; sel_last = axis_adc1_tlast; sel_dat = axis_adc1_tdata; end
            2'd2:    begin sel_vld = axis_adc2_tvalid; sel_last = axis_adc2_tlast; sel_dat = axis_adc2_tdata; end
            default: ;
        endcase
    end

    assign accept    = (state_q == GRANT) && sel_vld && out_free;
    assign burst_len = {1'b0, len_q} + 18'd1;

    // Round-robin scans the two other sources first and the previous winner last.
    always_comb begin
        rr1       = next_src(last_grant_q);
        rr2       = next_src(rr1);
        rr3       = next_src(rr2);
        force_idx = i_src_sel - 2'd1;
        pick_vld  = 1'b0;
        pick      = 2'd0;
        if (i_src_sel == 2'd0) begin
            if (in_vld[rr1]) begin
                pick_vld = 1'b1;
                pick     = rr1;
            end else if (in_vld[rr2]) begin
                pick_vld = 1'b1;
                pick     = rr2;
            end else if (in_vld[rr3]) begin
                pick_vld = 1'b1;
                pick     = rr3;
            end
        end else if (in_vld[force_idx]) begin
            pick_vld = 1'b1;
            pick     = force_idx;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        dat_d        = dat_q;
        vld_d        = vld_q;
        last_d       = last_q;
        tid_d        = tid_q;
        err_d        = err_q;

        if (accept) begin
            dat_d  = sel_dat;
            last_d = sel_last;
            tid_d  = grant_q;
            vld_d  = 1'b1;
        end else if (axis_sink_tready) begin
            vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    grant_d = pick;
                    len_d   = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    len_d = (len_q == '1) ? len_q : len_q + 17'd1;
                    if (sel_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                        if (burst_len < MIN_LEN || burst_len > MAX_LEN) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd2;
            len_q        <= '0;
            dat_q        <= '0;
            vld_q        <= 1'b0;
            last_q       <= 1'b0;
            tid_q        <= 2'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            dat_q        <= dat_d;
            vld_q        <= vld_d;
            last_q       <= last_d;
            tid_q        <= tid_d;
            err_q        <= err_d;
        end
    end

    assign axis_sink_tdata  = dat_q;
    assign axis_sink_tvalid = vld_q;
    assign axis_sink_tlast  = last_q;
    assign axis_sink_tid    = tid_q;
    assign burst_size_error = err_q;

endmodule

// File: tb/tb_beam_combiner.sv
// Bench for beam_combiner: random burst payloads, expected sink stream predicted from arbitration rules.
module tb_beam_combiner;

    localparam int MIN_B = 1024;
    localparam int MAX_B = 65536;

    typedef struct { logic [31:0] dat; logic last; int len; } beat_t;
    typedef struct { logic [31:0] dat; logic last; logic [1:0] tid; } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a0_dat = '0, a1_dat = '0, a2_dat = '0;
    logic        a0_vld = 1'b0, a1_vld = 1'b0, a2_vld = 1'b0;
    logic        a0_last = 1'b0, a1_last = 1'b0, a2_last = 1'b0;
    logic        a0_rdy, a1_rdy, a2_rdy;
    logic [1:0]  src_sel = 2'd0;
    logic [31:0] s_dat;
    logic        s_vld, s_last, s_rdy = 1'b1;
    logic [1:0]  s_tid;
    logic        err;

    beam_combiner #(.DATA_W(32), .MIN_BURST(MIN_B), .MAX_BURST(MAX_B)) dut (
        .i_clk(clk), .i_rst(rst),
        .axis_adc0_tdata(a0_dat), .axis_adc0_tvalid(a0_vld), .axis_adc0_tlast(a0_last), .axis_adc0_tready(a0_rdy),
        .axis_adc1_tdata(a1_dat), .axis_adc1_tvalid(a1_vld), .axis_adc1_tlast(a1_last), .axis_adc1_tready(a1_rdy),
        .axis_adc2_tdata(a2_dat), .axis_adc2_tvalid(a2_vld), .axis_adc2_tlast(a2_last), .axis_adc2_tready(a2_rdy),
        .i_src_sel(src_sel),
        .axis_sink_tdata(s_dat), .axis_sink_tvalid(s_vld), .axis_sink_tlast(s_last),
        .axis_sink_tid(s_tid), .axis_sink_tready(s_rdy),
        .burst_size_error(err)
    );

    always #5 clk = ~clk;

    beat_t q0[$], q1[$], q2[$];
    exp_t  exp_q[$];
    int    n_cmp = 0, n_bad = 0;
    int    rdy_mode = 0;      // 0: always ready, 1: toggle, 2: random
    logic  exp_err = 1'b0;
    logic  watch0 = 1'b0;
    logic  prev_stall = 1'b0;
    logic [31:0] hold_dat;
    logic  hold_last;
    logic [1:0] hold_tid;
    int    cyc = 0, t_start = 0, first_seen = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Queue a burst on source s; call order defines the expected sink order.
    task automatic push_burst(input int s, input int n);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            b.dat  = $urandom;
            b.last = (i == n - 1);
            b.len  = n;
            e.dat  = b.dat;
            e.last = b.last;
            e.tid  = 2'(s);
            exp_q.push_back(e);
            case (s)
                0:       q0.push_back(b);
                1:       q1.push_back(b);
                default: q2.push_back(b);
            endcase
        end
    endtask

    function automatic void retire(input beat_t b);
        if (b.last && (b.len < MIN_B || b.len > MAX_B)) exp_err = 1'b1;
    endfunction

    task automatic cycle();
        logic [2:0] hs;
        exp_t e;
        a0_vld = 1'b0; a0_dat = '0; a0_last = 1'b0;
        a1_vld = 1'b0; a1_dat = '0; a1_last = 1'b0;
        a2_vld = 1'b0; a2_dat = '0; a2_last = 1'b0;
        if (q0.size() > 0) begin a0_vld = 1'b1; a0_dat = q0[0].dat; a0_last = q0[0].last; end
        if (q1.size() > 0) begin a1_vld = 1'b1; a1_dat = q1[0].dat; a1_last = q1[0].last; end
        if (q2.size() > 0) begin a2_vld = 1'b1; a2_dat = q2[0].dat; a2_last = q2[0].last; end
        case (rdy_mode)
            0:       s_rdy = 1'b1;
            1:       s_rdy = !s_rdy;
            default: s_rdy = ($urandom_range(0, 3) != 0);
        endcase
        @(negedge clk);
        hs = {a2_vld && a2_rdy, a1_vld && a1_rdy, a0_vld && a0_rdy};
        chk("one_ready", 64'($countones({a2_rdy, a1_rdy, a0_rdy}) <= 1), 64'd1);
        if (watch0) chk("adc0_ready_forced", a0_rdy, 0);
        chk("err_flag", err, exp_err);
        if (prev_stall) begin
            chk("hold_vld", s_vld, 1);
            chk("hold_dat", s_dat, hold_dat);
            chk("hold_last", s_last, hold_last);
            chk("hold_tid", s_tid, hold_tid);
        end
        prev_stall = s_vld && !s_rdy;
        hold_dat = s_dat; hold_last = s_last; hold_tid = s_tid;
        if (first_seen < 0 && s_vld) first_seen = cyc - t_start;
        if (s_vld && s_rdy) begin
            chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sink_dat", s_dat, e.dat);
                chk("sink_last", s_last, e.last);
                chk("sink_tid", s_tid, e.tid);
            end
        end
        @(posedge clk);
        #1;
        if (hs[0] && q0.size() > 0) retire(q0.pop_front());
        if (hs[1] && q1.size() > 0) retire(q1.pop_front());
        if (hs[2] && q2.size() > 0) retire(q2.pop_front());
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0 || q2.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic pulse_reset();
        a0_vld = 1'b0; a1_vld = 1'b0; a2_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete(); q1.delete(); q2.delete(); exp_q.delete();
        prev_stall = 1'b0;
        exp_err = 1'b0;
        chk("rst_sink_vld", s_vld, 0);
        chk("rst_sink_last", s_last, 0);
        chk("rst_sink_dat", s_dat, 0);
        chk("rst_sink_tid", s_tid, 0);
        chk("rst_readys", {a2_rdy, a1_rdy, a0_rdy}, 0);
        chk("rst_err", err, 0);
    endtask

    initial begin
        int n;

        // Reset state
        pulse_reset();

        // Round-robin: three simultaneous 1024-beat bursts leave in order 0,1,2
        rdy_mode = 0;
        src_sel  = 2'd0;
        push_burst(0, 1024);
        push_burst(1, 1024);
        push_burst(2, 1024);
        t_start = cyc;
        first_seen = -1;
        drain("rr_drain", 4000);
        chk("first_beat_latency", 64'(first_seen), 64'd2);
        chk("rr_err", err, 0);

        // Forced adc1 while adc0 also waits
        rdy_mode = 2;
        src_sel  = 2'd2;
        push_burst(1, 1024);
        push_burst(0, 1024);
        watch0 = 1'b1;
        n = 0;
        while (exp_q.size() > 1024 && n < 3000) begin
            cycle();
            n++;
        end
        chk("forced_done", 64'(n < 3000), 64'd1);
        chk("forced_adc0_untouched", 64'(q0.size()), 64'd1024);
        watch0  = 1'b0;
        src_sel = 2'd0;
        drain("forced_tail_drain", 3000);

        // Sink ready toggling every cycle on a 2000-beat burst
        rdy_mode = 1;
        push_burst(2, 2000);
        drain("toggle_drain", 5000);
        chk("toggle_err", err, 0);

        // Reset mid-burst, then round-robin restarts at adc0
        rdy_mode = 0;
        push_burst(1, 1024);
        n = 0;
        while (q1.size() > 524 && n < 2000) begin
            cycle();
            n++;
        end
        chk("mid_burst_reached", 64'(q1.size()), 64'd524);
        pulse_reset();
        push_burst(0, 1024);
        push_burst(1, 1024);
        drain("post_rst_drain", 3000);
        chk("post_rst_err", err, 0);

        // Short burst sets the sticky flag, oversize burst still forwarded
        push_burst(2, 1023);
        drain("short_drain", 1500);
        chk("short_err_set", err, 1);
        push_burst(0, 65537);
        drain("long_drain", 66000);
        chk("long_err_sticky", err, 1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
